det_seq_nxn: RTL and testbench

- Parametrised, sequential successor to the team's combinational 3x3 determinant block.
- Computes a signed 2x2 or 3x3 determinant, selected per transaction, with a single shared multiplier.
- Uses valid/ready handshakes on the input and output sides.
- Sits between the matrix operand buffer and the result collector in the operations datapath.

---
 rtl/det_pkg.sv | 11 +
 rtl/det_mul.sv | 11 +
 rtl/det_seq_nxn.sv | 110 +++++++++++
 tb/tb_det_seq_nxn.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// det_pkg: shared FSM states, mode codes and schedule lengths for the sequential determinant block.
package det_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic MODE_2X2 = 1'b0;
  localparam logic MODE_3X3 = 1'b1;
  localparam int STEPS_2X2 = 2;
  localparam int STEPS_3X3 = 9;
  function automatic int step_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/det_mul.sv
// det_mul: combinational signed multiplier with a full-precision product.
module det_mul #(
  parameter int A_W = 8,
  parameter int B_W = 17
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/det_seq_nxn.sv
// det_seq_nxn: 2x2/3x3 signed determinant, one shared multiply per clock, valid/ready on both sides.
// Optional `singular` output is enabled by defining DET_SEQ_SINGULAR_EN.
module det_seq_nxn
  import det_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int DET_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [9*ELEM_W-1:0] matrix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DET_W-1:0]  det
`ifdef DET_SEQ_SINGULAR_EN
  ,
  output logic              singular
`endif
);
  localparam int MW = 2*ELEM_W+1;
  localparam int PW = 3*ELEM_W+1;
  localparam int AW = 3*ELEM_W+3;
  localparam int SW = step_w(STEPS_3X3);
  if (DET_W < 3*ELEM_W+3) begin : g_width_chk
    $error("det_seq_nxn: DET_W must be at least 3*ELEM_W+3");
  end
  state_t state, state_nx;
  logic [SW-1:0] step;
  logic md;
  logic signed [ELEM_W-1:0] el [9];
  logic signed [MW-1:0] m1, m2, m3, m_cur, m_nx;
  logic signed [AW-1:0] acc, acc_nx;
  logic signed [ELEM_W-1:0] op_a;
  logic signed [MW-1:0] op_b;
  logic signed [PW-1:0] prod;
  logic last, is_set, is_add, is_acc;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last = state == CALC && step == SW'(md == MODE_3X3 ? STEPS_3X3-1 : STEPS_2X2-1);
  assign state_nx = state == IDLE ? (in_valid ? CALC : IDLE)
                  : state == CALC ? (last ? DONE : CALC)
                  : (out_ready ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Cofactors m1..m3 are built first (steps 0-5), then expanded along the top row (steps 6-8).
  always_comb begin
    op_a = el[0];
    op_b = MW'(el[4]);
    if (md == MODE_2X2) begin
      op_a = step == '0 ? el[0] : el[1];
      op_b = step == '0 ? MW'(el[4]) : MW'(el[3]);
    end else
      case (step)
        SW'(0): begin op_a = el[4]; op_b = MW'(el[8]); end
        SW'(1): begin op_a = el[5]; op_b = MW'(el[7]); end
        SW'(2): begin op_a = el[3]; op_b = MW'(el[8]); end
        SW'(3): begin op_a = el[5]; op_b = MW'(el[6]); end
        SW'(4): begin op_a = el[3]; op_b = MW'(el[7]); end
        SW'(5): begin op_a = el[4]; op_b = MW'(el[6]); end
        SW'(6): begin op_a = el[0]; op_b = m1; end
        SW'(7): begin op_a = el[1]; op_b = m2; end
        default: begin op_a = el[2]; op_b = m3; end
      endcase
  end
  det_mul #(.A_W(ELEM_W), .B_W(MW)) u_mul (.a(op_a), .b(op_b), .p(prod));
  assign is_acc = md == MODE_2X2 || step >= SW'(6);
  assign is_set = md == MODE_2X2 ? step == '0 : (step < SW'(6) ? !step[0] : step == SW'(6));
  assign is_add = md == MODE_3X3 && step == SW'(8);
  assign m_cur  = step < SW'(2) ? m1 : step < SW'(4) ? m2 : m3;
  assign m_nx   = is_set ? prod[MW-1:0] : m_cur - prod[MW-1:0];
  assign acc_nx = is_set ? AW'(prod) : is_add ? acc + AW'(prod) : acc - AW'(prod);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step <= '0;
      md   <= MODE_2X2;
      el   <= '{default: '0};
      m1   <= '0;
      m2   <= '0;
      m3   <= '0;
      acc  <= '0;
      det  <= '0;
`ifdef DET_SEQ_SINGULAR_EN
      singular <= 1'b0;
`endif
    end else if (in_valid && in_ready) begin
      md <= mode;
      for (int k = 0; k < 9; k++) el[k] <= matrix[(9-k)*ELEM_W-1 -: ELEM_W];
      m1   <= '0;
      m2   <= '0;
      m3   <= '0;
      acc  <= '0;
      step <= '0;
    end else if (state == CALC) begin
      step <= step + 1'b1;
      if (is_acc) acc <= acc_nx;
      else if (step < SW'(2)) m1 <= m_nx;
      else if (step < SW'(4)) m2 <= m_nx;
      else m3 <= m_nx;
      if (last) begin
        det <= DET_W'(acc_nx);
`ifdef DET_SEQ_SINGULAR_EN
        singular <= acc_nx == '0;
`endif
      end
    end
endmodule

// File: tb/tb_det_seq_nxn.sv
// tb_det_seq_nxn: directed table, backpressure/reset sequences and random 2x2/3x3 checks against a Leibniz-formula model.
module tb_det_seq_nxn;
  localparam int EW = 8;
  localparam int DW = 32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, mode = 1'b0;
  logic [9*EW-1:0] matrix = '0;
  logic out_valid, out_ready = 1'b1;
  logic [DW-1:0] det;
`ifdef DET_SEQ_SINGULAR_EN
  logic singular;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  det_seq_nxn #(.ELEM_W(EW), .DET_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .matrix(matrix), .out_valid(out_valid), .out_ready(out_ready), .det(det)
`ifdef DET_SEQ_SINGULAR_EN
    , .singular(singular)
`endif
  );
  typedef struct {
    logic   md;
    int     el [9];
    longint d;
  } vec_t;
  function automatic void chk(input string nm, input logic signed [63:0] act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  function automatic longint ref_det(input logic md, input int el [9]);
    longint a = el[0], b = el[1], c = el[2], d = el[3], e = el[4];
    longint f = el[5], g = el[6], h = el[7], i = el[8];
    return md ? a*e*i + b*f*g + c*d*h - c*e*g - b*d*i - a*f*h : a*e - b*d;
  endfunction
  function automatic longint sdet();
    return longint'($signed(det));
  endfunction
  task automatic drive(input logic md, input int el [9]);
    mode = md;
    for (int k = 0; k < 9; k++) matrix[(9-k)*EW-1 -: EW] = el[k][EW-1:0];
  endtask
  task automatic accept(input logic md, input int el [9], input string nm);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk({nm, "_rdy"}, in_ready, 1);
    drive(md, el);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    matrix = {$urandom, $urandom, $urandom};
    mode = $urandom_range(0, 1);
  endtask
  task automatic wait_out(input logic md, input longint dexp, input string nm);
    int lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, "_lat"}, lat, md ? 9 : 2);
    chk({nm, "_det"}, sdet(), dexp);
`ifdef DET_SEQ_SINGULAR_EN
    chk({nm, "_sing"}, singular, dexp == 0 ? 1 : 0);
`endif
  endtask
  task automatic handshake(input int stall, input longint dexp, input string nm);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_v"}, out_valid, 1);
      chk({nm, "_hold_d"}, sdet(), dexp);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_drop_v"}, out_valid, 0);
    chk({nm, "_keep_d"}, sdet(), dexp);
  endtask
  task automatic txn(input logic md, input int el [9], input longint dexp, input int stall, input string nm);
    out_ready = stall == 0;
    accept(md, el, nm);
    wait_out(md, dexp, nm);
    handshake(stall, dexp, nm);
  endtask
  vec_t tv [6];
  initial begin
    int ident [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int m49 [9]   = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    int m2x2 [9]  = '{3, 5, 127, 2, 7, 127, 127, 127, 127};
    int el [9];
    logic md;
    tv[0] = '{1'b1, ident, 1};
    tv[1] = '{1'b1, m49, 49};
    tv[2] = '{1'b1, '{2, 0, -1, 2, -3, 1, 1, 4, 5}, -49};
    tv[3] = '{1'b1, '{-128, 0, 0, 0, -128, 0, 0, 0, -128}, -2097152};
    tv[4] = '{1'b1, '{-128, -128, -128, -128, -128, -128, -128, -128, -128}, 0};
    tv[5] = '{1'b0, m2x2, 11};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_det", sdet(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    for (int t = 0; t < 6; t++) txn(tv[t].md, tv[t].el, tv[t].d, 0, $sformatf("vec%0d", t));
    out_ready = 1'b0;
    accept(1'b1, m49, "bp");
    wait_out(1'b1, 49, "bp");
    @(negedge clk);
    drive(1'b0, m2x2);
    in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_d", sdet(), 49);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_v", out_valid, 0);
    chk("bp_release_rdy", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_next_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_out(1'b0, 11, "bp_next");
    handshake(0, 11, "bp_next");
    accept(1'b1, m49, "rst_mid");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_det", sdet(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_rdy", in_ready, 1);
    chk("rst_mid_valid2", out_valid, 0);
    txn(1'b1, ident, 1, 0, "post_rst");
    for (int r = 0; r < 60; r++) begin
      md = $urandom_range(0, 1);
      for (int k = 0; k < 9; k++) el[k] = int'($urandom_range(0, 255)) - 128;
      txn(md, el, ref_det(md, el), $urandom_range(0, 2), $sformatf("rnd%0d", r));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
